sdram_access_bridge: RTL and testbench



---
 rtl/knn_pkg.sv | 14 +
 rtl/bridge_fifo.sv | 71 +++++++
 rtl/sdram_access_bridge.sv | 172 +++++++++++++++++
 tb/tb_sdram_access_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared widths and bridge state encoding for the SDRAM access path
package knn_pkg;

    localparam int KNN_W      = 16;
    localparam int KNN_ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/bridge_fifo.sv
// rtl/bridge_fifo.sv - posted-write FIFO, head word visible on dout while non-empty
module bridge_fifo
    import knn_pkg::*;
#(
    parameter int WIDTH = KNN_W + KNN_ADDR_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this same cycle, so a full FIFO still takes a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sdram_access_bridge.sv
// rtl/sdram_access_bridge.sv - strobe-to-Avalon-MM bridge with posted writes and ordered single reads
module sdram_access_bridge
    import knn_pkg::*;
#(
    parameter int W          = KNN_W,
    parameter int ADDR_W     = KNN_ADDR_W,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeaddress,
    input  logic [W-1:0]      writedata,
    input  logic              read,
    input  logic [ADDR_W-1:0] readaddress,
    output logic [W-1:0]      readdata,
    output logic              read_valid,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [W-1:0]      avm_writedata,
    output logic [W/8-1:0]    avm_byteenable,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [W-1:0]      avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int FW    = ADDR_W + W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FW-1:0]    fifo_dout;
    logic [CNT_W-1:0] fifo_count;

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [W-1:0]      avm_writedata_q, avm_writedata_d;
    logic              avm_write_q, avm_write_d;
    logic              avm_read_q, avm_read_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              pend_q, pend_d;
    logic [W-1:0]      readdata_q, readdata_d;
    logic              read_valid_q, read_valid_d;
    logic              error_q, error_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    assign fifo_pop  = (state_q == WR_ISSUE) && !avm_waitrequest;
    assign fifo_push = write && (!fifo_full || fifo_pop);

    bridge_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({writeaddress, writedata}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d         = state_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        avm_write_d     = avm_write_q;
        avm_read_d      = avm_read_q;
        rd_addr_d       = rd_addr_q;
        pend_d          = pend_q;
        readdata_d      = readdata_q;
        read_valid_d    = 1'b0;
        tmo_d           = tmo_q;
        error_d         = error_q | (write && !fifo_push) | (read && pend_q);

        if (read && !pend_q) begin
            pend_d    = 1'b1;
            rd_addr_d = readaddress;
        end

        case (state_q)
            IDLE: begin
                // Writes win so a pending read always observes every queued write.
                if (!fifo_empty) begin
                    state_d         = WR_ISSUE;
                    avm_write_d     = 1'b1;
                    avm_address_d   = fifo_dout[FW-1:W];
                    avm_writedata_d = fifo_dout[W-1:0];
                end else if (pend_q) begin
                    state_d       = RD_ISSUE;
                    avm_read_d    = 1'b1;
                    avm_address_d = rd_addr_q;
                end
            end
            WR_ISSUE: begin
                if (!avm_waitrequest) begin
                    avm_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    readdata_d   = avm_readdata;
                    read_valid_d = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = IDLE;
                end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
                    readdata_d   = '0;
                    read_valid_d = 1'b1;
                    error_d      = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_write_q     <= 1'b0;
            avm_read_q      <= 1'b0;
            rd_addr_q       <= '0;
            pend_q          <= 1'b0;
            readdata_q      <= '0;
            read_valid_q    <= 1'b0;
            error_q         <= 1'b0;
            tmo_q           <= '0;
        end else begin
            state_q         <= state_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_write_q     <= avm_write_d;
            avm_read_q      <= avm_read_d;
            rd_addr_q       <= rd_addr_d;
            pend_q          <= pend_d;
            readdata_q      <= readdata_d;
            read_valid_q    <= read_valid_d;
            error_q         <= error_d;
            tmo_q           <= tmo_d;
        end
    end

    assign readdata       = readdata_q;
    assign read_valid     = read_valid_q;
    assign error          = error_q;
    assign avm_address    = avm_address_q;
    assign avm_writedata  = avm_writedata_q;
    assign avm_write      = avm_write_q;
    assign avm_read       = avm_read_q;
    assign avm_byteenable = '1;
    assign busy           = (fifo_count != '0) || pend_q || (state_q != IDLE);

endmodule

// File: tb/tb_sdram_access_bridge.sv
// tb/tb_sdram_access_bridge.sv - self-checking bench for sdram_access_bridge
module tb_sdram_access_bridge;

    localparam int W   = 16;
    localparam int AW  = 25;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst, write, read;
    logic [AW-1:0] writeaddress, readaddress, avm_address;
    logic [W-1:0]  writedata, readdata, avm_writedata, avm_readdata;
    logic          read_valid, busy, error, avm_write, avm_read;
    logic [W/8-1:0] avm_byteenable;
    logic          avm_waitrequest, avm_readdatavalid;

    always #5 clk = ~clk;

    sdram_access_bridge #(.W(W), .ADDR_W(AW), .FIFO_DEPTH(8), .RD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .write(write), .writeaddress(writeaddress), .writedata(writedata),
        .read(read), .readaddress(readaddress), .readdata(readdata), .read_valid(read_valid),
        .busy(busy), .error(error), .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
    typedef struct { bit is_rd; logic [AW-1:0] addr; logic [W-1:0] data; logic [W-1:0] exp; } vec_t;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    wr_t exp_wq[$], got_wq[$];
    logic [W-1:0] slave_mem [int];
    logic [W-1:0] ref_mem [int];
    bit   wr_rand = 0, mute = 0;
    int   rdv_cnt = 0, rv_cnt = 0, rv_cyc = 0, rhs_cnt = 0, rhs_cyc = 0;
    int   whs_cyc = 0, rdv_cyc = 0, first_rd_cyc = -1;
    logic [W-1:0] rdv_data, rv_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: record handshakes seen this cycle, advance, then play the SDRAM slave.
    task automatic step();
        bit hw, hr;
        logic [AW-1:0] a;
        logic [W-1:0] d;
        hw = avm_write && !avm_waitrequest;
        hr = avm_read && !avm_waitrequest;
        a  = avm_address;
        d  = avm_writedata;
        if (hw) whs_cyc = cyc;
        if (hr) begin rhs_cyc = cyc; rhs_cnt++; end
        if (avm_read && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (avm_readdatavalid) rdv_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        write = 0; read = 0; avm_readdatavalid = 0;
        if (hw) begin slave_mem[int'(a)] = d; got_wq.push_back('{a, d}); end
        if (hr && !mute) begin
            rdv_cnt  = $urandom_range(1, 3);
            rdv_data = slave_mem.exists(int'(a)) ? slave_mem[int'(a)] : '0;
        end
        if (rdv_cnt > 0) begin
            rdv_cnt--;
            if (rdv_cnt == 0) begin avm_readdatavalid = 1; avm_readdata = rdv_data; end
        end
        if (wr_rand) avm_waitrequest = ($urandom_range(0, 2) == 0);
        if (read_valid) begin rv_cnt++; rv_cyc = cyc; rv_data = readdata; end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) step();
        chk({name, " idle"}, busy, 0);
    endtask

    task automatic wait_rv(input string name);
        int start;
        start = rv_cnt;
        for (int i = 0; i < 200 && rv_cnt == start; i++) step();
        chk({name, " read_valid seen"}, rv_cnt != start, 1);
    endtask

    task automatic check_writes(input string name);
        chk({name, " wr count"}, got_wq.size(), exp_wq.size());
        for (int i = 0; i < exp_wq.size() && i < got_wq.size(); i++) begin
            chk({name, " wr addr"}, got_wq[i].addr, exp_wq[i].addr);
            chk({name, " wr data"}, got_wq[i].data, exp_wq[i].data);
        end
        exp_wq.delete();
        got_wq.delete();
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        write = 1; writeaddress = a; writedata = d;
        exp_wq.push_back('{a, d});
        ref_mem[int'(a)] = d;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
        rdv_cnt = 0;
        exp_wq.delete(); got_wq.delete();
    endtask

    initial begin
        vec_t vt[9];
        int s, n, ra;
        logic [W-1:0] ev;
        vt[0] = '{0, 25'h10,      16'h0003, 16'h0000};
        vt[1] = '{0, 25'h11,      16'hBEEF, 16'h0000};
        vt[2] = '{1, 25'h10,      16'h0000, 16'h0003};
        vt[3] = '{1, 25'h11,      16'h0000, 16'hBEEF};
        vt[4] = '{0, 25'h10,      16'h1234, 16'h0000};
        vt[5] = '{1, 25'h10,      16'h0000, 16'h1234};
        vt[6] = '{1, 25'h55,      16'h0000, 16'h0000};
        vt[7] = '{0, 25'h1FFFFFF, 16'hFFFF, 16'h0000};
        vt[8] = '{1, 25'h1FFFFFF, 16'h0000, 16'hFFFF};

        rst = 1; write = 0; read = 0; writeaddress = '0; writedata = '0; readaddress = '0;
        avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
        do_reset();
        chk("rst readdata", readdata, 0);
        chk("rst read_valid", read_valid, 0);
        chk("rst error", error, 0);
        chk("rst avm_write", avm_write, 0);
        chk("rst avm_read", avm_read, 0);
        chk("rst avm_address", avm_address, 0);
        chk("rst avm_writedata", avm_writedata, 0);
        chk("rst busy", busy, 0);

        // Single write latency
        push_wr(25'h10, 16'h0003);
        step(); chk("wr t+1 avm_write", avm_write, 0);
        step(); chk("wr t+2 avm_write", avm_write, 1);
        chk("wr t+2 addr", avm_address, 25'h10);
        chk("wr t+2 data", avm_writedata, 16'h0003);
        chk("wr byteenable", avm_byteenable, 2'b11);
        step(); chk("wr t+3 avm_write", avm_write, 0);
        step(); chk("wr t+4 busy", busy, 0);
        check_writes("single wr");

        for (int i = 0; i < 9; i++) begin
            if (vt[i].is_rd) begin
                read = 1; readaddress = vt[i].addr;
                step();
                wait_rv($sformatf("vec%0d", i));
                chk($sformatf("vec%0d readdata", i), rv_data, vt[i].exp);
            end else begin
                push_wr(vt[i].addr, vt[i].data);
                step();
                wait_idle($sformatf("vec%0d", i));
                check_writes($sformatf("vec%0d", i));
            end
        end

        // Read right after write must follow the write handshake
        first_rd_cyc = -1;
        push_wr(25'h20, 16'h0042);
        step();
        read = 1; readaddress = 25'h20;
        step();
        s = rv_cnt;
        wait_rv("raw");
        step(); step(); step();
        chk("raw read after write hs", first_rd_cyc > whs_cyc, 1);
        chk("raw readdata", rv_data, 16'h0042);
        chk("raw pulse count", rv_cnt - s, 1);
        chk("raw rv latency", rv_cyc - rdv_cyc, 1);
        check_writes("raw");

        // Waitrequest stall on a read
        avm_waitrequest = 1;
        s = rhs_cnt;
        read = 1; readaddress = 25'h30;
        step(); chk("rd t+1 avm_read", avm_read, 0);
        step(); chk("rd t+2 avm_read", avm_read, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall avm_read", avm_read, 1);
            chk("stall avm_address", avm_address, 25'h30);
            step();
        end
        avm_waitrequest = 0;
        chk("accept avm_read", avm_read, 1);
        chk("accept avm_address", avm_address, 25'h30);
        step(); chk("after accept avm_read", avm_read, 0);
        wait_rv("stall");
        chk("stall single request", rhs_cnt - s, 1);
        chk("stall readdata", rv_data, 16'h0000);

        // Burst overflow with the controller stalled
        avm_waitrequest = 1;
        for (int i = 0; i < 10; i++) begin
            write = 1; writeaddress = 25'h100 + 25'(i); writedata = 16'hA000 + 16'(i);
            if (i < 8) exp_wq.push_back('{25'h100 + 25'(i), 16'hA000 + 16'(i)});
            step();
            if (i == 7) chk("ovf error before drop", error, 0);
            if (i == 8) chk("ovf error on drop", error, 1);
        end
        avm_waitrequest = 0;
        wait_idle("ovf");
        check_writes("ovf");
        chk("ovf error sticky", error, 1);
        do_reset();

        // Timeout: first a good read so readdata is non-zero
        push_wr(25'h40, 16'h4444); step(); wait_idle("tmo pre");
        check_writes("tmo pre");
        read = 1; readaddress = 25'h40; step(); wait_rv("tmo pre");
        chk("tmo pre readdata", rv_data, 16'h4444);
        mute = 1;
        read = 1; readaddress = 25'h40; step();
        wait_rv("tmo");
        chk("tmo readdata", rv_data, 16'h0000);
        chk("tmo error", error, 1);
        chk("tmo cycles", rv_cyc - rhs_cyc, TMO + 1);
        s = rv_cnt;
        avm_readdatavalid = 1; avm_readdata = 16'hDEAD;
        step(); step();
        chk("late rdv readdata", readdata, 16'h0000);
        chk("late rdv no pulse", rv_cnt - s, 0);

        // Reset while waiting for read data
        read = 1; readaddress = 25'h50; step();
        s = rhs_cnt;
        for (int i = 0; i < 50 && rhs_cnt == s; i++) step();
        chk("rst-rd accepted", rhs_cnt - s, 1);
        step();
        rst = 1; step(); rst = 0;
        rdv_cnt = 0;
        chk("rst-rd avm_write", avm_write, 0);
        chk("rst-rd avm_read", avm_read, 0);
        chk("rst-rd avm_address", avm_address, 0);
        chk("rst-rd busy", busy, 0);
        chk("rst-rd error", error, 0);
        avm_readdatavalid = 1; avm_readdata = 16'hBEEF;
        step();
        chk("rst-rd stale read_valid", read_valid, 0);
        chk("rst-rd stale readdata", readdata, 16'h0000);
        mute = 0;
        got_wq.delete(); exp_wq.delete();
        push_wr(25'h60, 16'h0606); step();
        wait_idle("rst-rd wr");
        check_writes("rst-rd wr");

        // Random bursts with random stalls against a plain memory model
        wr_rand = 1;
        for (int it = 0; it < 25; it++) begin
            n  = $urandom_range(1, 6);
            ra = 'h200 + $urandom_range(0, 8);
            s  = $urandom_range(0, 1);
            for (int j = 0; j < n; j++) begin
                push_wr(25'h200 + 25'($urandom_range(0, 7)), 16'($urandom));
                if (j == n - 1 && s == 1) begin read = 1; readaddress = 25'(ra); end
                step();
            end
            if (s == 0) begin read = 1; readaddress = 25'(ra); step(); end
            ev = ref_mem.exists(ra) ? ref_mem[ra] : '0;
            wait_rv($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d readdata", it), rv_data, ev);
            wait_idle($sformatf("rnd%0d", it));
            check_writes($sformatf("rnd%0d", it));
        end
        wr_rand = 0; avm_waitrequest = 0;
        step();
        chk("rnd no error", error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
